sid_i2s_out: RTL and testbench

SID_I2S_OUT -- requirements
Module: sid_i2s_out

---
 rtl/sid_pkg.sv | 27 ++
 rtl/sid_i2s_fifo.sv | 50 +++++
 rtl/sid_i2s_out.sv | 121 ++++++++++++
 tb/tb_sid_i2s_out.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared constants and helpers for the SID audio output path.
package sid_pkg;

  localparam int I2S_SLOT_BITS  = 16;
  localparam int I2S_FRAME_BITS = 32;
  localparam int SOUND_W        = 18;

  // 16-bit saturation limits expressed in the 18-bit sound domain
  localparam logic signed [SOUND_W-1:0] SAT_MAX = 18'sh07FFF;
  localparam logic signed [SOUND_W-1:0] SAT_MIN = 18'sh38000;

  typedef logic [I2S_SLOT_BITS-1:0] sample_t;

  // Clamp an 18-bit signed value into a 16-bit signed word (no rounding)
  function automatic sample_t sat16(input logic signed [SOUND_W-1:0] v);
    sample_t r;
    if (v > SAT_MAX) begin
      r = 16'h7FFF;
    end else if (v < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = v[I2S_SLOT_BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sid_i2s_fifo.sv
// Two-entry sample FIFO. A pop in the same cycle as a push is applied first,
// so a push into a full FIFO is accepted when it coincides with a pop.
module sid_i2s_fifo
  import sid_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic [1:0] level
);

  sample_t mem0;  // head
  sample_t mem1;  // second entry
  logic    do_pop;
  logic    do_push;

  assign do_pop  = pop && (level != 2'd0);
  assign do_push = push && ((level != 2'd2) || do_pop);
  assign dout    = mem0;

  // Storage and occupancy update, pop-before-push
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0  <= '0;
      mem1  <= '0;
      level <= 2'd0;
    end else if (do_pop && do_push) begin
      if (level == 2'd1) begin
        mem0 <= din;
      end else begin
        mem0 <= mem1;
        mem1 <= din;
      end
    end else if (do_pop) begin
      mem0  <= mem1;
      level <= level - 2'd1;
    end else if (do_push) begin
      if (level == 2'd0) begin
        mem0 <= din;
      end else begin
        mem1 <= din;
      end
      level <= level + 2'd1;
    end
  end

endmodule

// File: rtl/sid_i2s_out.sv
// Converts the 18-bit mixed SID sample to 16 bits and streams it as a mono
// Philips I2S frame (same word in left and right slot).
// sound_valid is a one-cycle strobe with no back-pressure: a sample offered
// while the FIFO is full and not being popped is dropped and flagged.
module sid_i2s_out
  import sid_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int GAIN     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOUND_W-1:0] sound,
  input  logic               sound_valid,
  input  logic               clr_status,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sdata,
  output logic [1:0]         fifo_level,
  output logic               overflow,
  output logic               underflow
);

  localparam int         SHIFT    = 2 - GAIN;
  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(I2S_FRAME_BITS - 1);

  logic signed [SOUND_W-1:0] shifted;
  sample_t                   conv;
  sample_t                   fifo_dout;
  logic                      fifo_pop;

  logic [7:0] div_cnt, div_nxt;
  logic       bclk_nxt, lrclk_nxt, sdata_nxt;
  logic [4:0] bit_cnt, bit_nxt;
  sample_t    frame, frame_nxt;
  logic       uf_evt, of_evt;

  assign shifted = $signed(sound) >>> SHIFT;
  assign conv    = sat16(shifted);
  assign of_evt  = sound_valid && (fifo_level == 2'd2) && !fifo_pop;

  sid_i2s_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sound_valid),
    .pop   (fifo_pop),
    .din   (conv),
    .dout  (fifo_dout),
    .level (fifo_level)
  );

  // Divider, bit counter and serializer next state; outputs move only on BCLK fall
  always_comb begin
    div_nxt   = div_cnt + 8'd1;
    bclk_nxt  = i2s_bclk;
    lrclk_nxt = i2s_lrclk;
    sdata_nxt = i2s_sdata;
    bit_nxt   = bit_cnt;
    frame_nxt = frame;
    fifo_pop  = 1'b0;
    uf_evt    = 1'b0;
    if (div_cnt == DIV_LAST) begin
      div_nxt  = 8'd0;
      bclk_nxt = ~i2s_bclk;
      if (i2s_bclk) begin
        bit_nxt = bit_cnt + 5'd1;
        if (bit_cnt == BIT_LAST) begin
          if (fifo_level != 2'd0) begin
            fifo_pop  = 1'b1;
            frame_nxt = fifo_dout;
          end else begin
            uf_evt = 1'b1;
          end
        end
        // left slot uses frame[15-n], right slot frame[31-n]: both are ~n[3:0]
        sdata_nxt = frame_nxt[~bit_nxt[3:0]];
        lrclk_nxt = (bit_nxt >= 5'd15) && (bit_nxt <= 5'd30);
      end
    end
  end

  // Serializer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= 8'd0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      bit_cnt   <= BIT_LAST;
      frame     <= '0;
    end else begin
      div_cnt   <= div_nxt;
      i2s_bclk  <= bclk_nxt;
      i2s_lrclk <= lrclk_nxt;
      i2s_sdata <= sdata_nxt;
      bit_cnt   <= bit_nxt;
      frame     <= frame_nxt;
    end
  end

  // Sticky status flags; a set event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (of_evt) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end
      if (uf_evt) begin
        underflow <= 1'b1;
      end else if (clr_status) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sid_i2s_out.sv
// Directed bench for sid_i2s_out: main instance GAIN=0, second instance GAIN=2.
module tb_sid_i2s_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sound;
  logic        sound_valid;
  logic        clr_status;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [1:0]  fifo_level;
  logic        overflow, underflow;

  logic [17:0] sound_g2;
  logic        valid_g2;
  logic        g2_bclk, g2_lrclk, g2_sdata;
  logic [1:0]  g2_level;
  logic        g2_overflow, g2_underflow;

  int pass_cnt;
  int chk_cnt;

  sid_i2s_out #(.BCLK_DIV(4), .GAIN(0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .sound       (sound),
    .sound_valid (sound_valid),
    .clr_status  (clr_status),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  sid_i2s_out #(.BCLK_DIV(4), .GAIN(2)) u_dut_g2 (
    .clk         (clk),
    .rst         (rst),
    .sound       (sound_g2),
    .sound_valid (valid_g2),
    .clr_status  (1'b0),
    .i2s_bclk    (g2_bclk),
    .i2s_lrclk   (g2_lrclk),
    .i2s_sdata   (g2_sdata),
    .fifo_level  (g2_level),
    .overflow    (g2_overflow),
    .underflow   (g2_underflow)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic push(input logic [17:0] v);
    @(negedge clk);
    sound_valid = 1'b1;
    sound       = v;
    @(negedge clk);
    sound_valid = 1'b0;
  endtask

  task automatic push_g2(input logic [17:0] v);
    @(negedge clk);
    valid_g2 = 1'b1;
    sound_g2 = v;
    @(negedge clk);
    valid_g2 = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  // Wait for a rising lrclk on the main instance (start of right slot)
  task automatic wait_mid();
    logic pl;
    bit   hit;
    hit = 1'b0;
    pl  = i2s_lrclk;
    for (int c = 0; c < 600 && !hit; c++) begin
      @(negedge clk);
      if (!pl && i2s_lrclk) hit = 1'b1;
      pl = i2s_lrclk;
    end
    chk_cnt++;
    if (!hit) $display("FAIL wait_mid: lrclk rise not seen, got 0 required 1");
    else pass_cnt++;
  endtask

  // Collect 32 bits sampled on rising bclk. sync: first wait for lrclk fall.
  // skip: rising edges to ignore before the first collected bit.
  task automatic capture(input int which, input bit sync, input int skip,
                         output logic [31:0] bits, output logic [31:0] lr);
    logic pb, pl, b, l, s;
    int   rises, sk;
    bit   armed, done;
    bits  = '0;
    lr    = '0;
    rises = 0;
    sk    = skip;
    armed = !sync;
    done  = 1'b0;
    pb = (which == 0) ? i2s_bclk  : g2_bclk;
    pl = (which == 0) ? i2s_lrclk : g2_lrclk;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      b = (which == 0) ? i2s_bclk  : g2_bclk;
      l = (which == 0) ? i2s_lrclk : g2_lrclk;
      s = (which == 0) ? i2s_sdata : g2_sdata;
      if (!armed) begin
        if (pl && !l) armed = 1'b1;
      end else if (b && !pb) begin
        if (sk > 0) begin
          sk--;
        end else begin
          bits[5'(31 - rises)] = s;
          lr[5'(rises)]        = l;
          rises++;
          if (rises == 32) done = 1'b1;
        end
      end
      pb = b;
      pl = l;
    end
    chk_cnt++;
    if (!done) $display("FAIL capture_timeout: got %0d bits required 32", rises);
    else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    rst = 1'b1;
    sound_valid = 1'b1;
    sound = 18'h00004;
    valid_g2 = 1'b1;
    sound_g2 = 18'h00004;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata} !== 3'b000)
      $display("FAIL reset_i2s: got %b required 000", {i2s_bclk, i2s_lrclk, i2s_sdata});
    else pass_cnt++;
    chk_cnt++;
    if (fifo_level !== 2'd0 || g2_level !== 2'd0)
      $display("FAIL reset_level: got %0d/%0d required 0/0", fifo_level, g2_level);
    else pass_cnt++;
    chk_cnt++;
    if ({overflow, underflow} !== 2'b00)
      $display("FAIL reset_flags: got %b required 00", {overflow, underflow});
    else pass_cnt++;
    sound_valid = 1'b0;
    valid_g2 = 1'b0;
    rst = 1'b0;
    n = 0;
    while (i2s_bclk !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n !== 4) $display("FAIL reset_first_rise: got %0d cycles required 4", n);
    else pass_cnt++;
  endtask

  task automatic test_conv();
    logic [31:0] bits, lr;
    wait_mid();
    push_g2(18'h1FFFF);
    push_g2(18'h20000);
    capture(1, 1'b1, 1, bits, lr);
    chk_cnt++;
    if (bits !== 32'h7FFF7FFF) $display("FAIL conv_pos_sat: got %h required 7fff7fff", bits);
    else pass_cnt++;
    capture(1, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h80008000) $display("FAIL conv_neg_sat: got %h required 80008000", bits);
    else pass_cnt++;
  endtask

  task automatic test_serial();
    logic [31:0] bits, lr;
    int n, hi, per;
    wait_mid();
    push(18'h00004);
    push(18'h2970C);
    capture(0, 1'b1, 1, bits, lr);
    chk_cnt++;
    if (bits !== 32'h00010001) $display("FAIL conv_gain0: got %h required 00010001", bits);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'hA5C3A5C3) $display("FAIL serial_data: got %h required a5c3a5c3", bits);
    else pass_cnt++;
    chk_cnt++;
    if (lr !== 32'h7FFF8000) $display("FAIL serial_lrclk: got %h required 7fff8000", lr);
    else pass_cnt++;
    n = 0;
    while (i2s_bclk !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    while (i2s_bclk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    hi = 0;
    while (i2s_bclk === 1'b1 && hi < 20) begin @(negedge clk); hi++; end
    per = hi;
    while (i2s_bclk === 1'b0 && per < 40) begin @(negedge clk); per++; end
    chk_cnt++;
    if (hi !== 4 || per !== 8)
      $display("FAIL bclk_period: got high %0d period %0d required 4 8", hi, per);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] bits, lr;
    wait_mid();
    pulse_clr();
    chk_cnt++;
    if ({overflow, underflow} !== 2'b00) $display("FAIL clr_both: got %b required 00", {overflow, underflow});
    else pass_cnt++;
    push(18'h04444);
    chk_cnt++;
    if (fifo_level !== 2'd1) $display("FAIL ovf_level1: got %0d required 1", fifo_level);
    else pass_cnt++;
    push(18'h08888);
    chk_cnt++;
    if (fifo_level !== 2'd2 || overflow !== 1'b0)
      $display("FAIL ovf_level2: got level %0d ovf %b required 2 0", fifo_level, overflow);
    else pass_cnt++;
    // third sample offered together with a clear: the set must win
    @(negedge clk);
    sound_valid = 1'b1;
    sound = 18'h0CCCC;
    clr_status = 1'b1;
    @(negedge clk);
    sound_valid = 1'b0;
    clr_status = 1'b0;
    chk_cnt++;
    if (fifo_level !== 2'd2 || overflow !== 1'b1)
      $display("FAIL ovf_drop: got level %0d ovf %b required 2 1", fifo_level, overflow);
    else pass_cnt++;
    pulse_clr();
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b required 0", overflow);
    else pass_cnt++;
    capture(0, 1'b1, 1, bits, lr);
    chk_cnt++;
    if (bits !== 32'h11111111) $display("FAIL ovf_first: got %h required 11111111", bits);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h22222222) $display("FAIL ovf_second: got %h required 22222222", bits);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    logic [31:0] bits, lr;
    wait_mid();
    pulse_clr();
    push(18'h048D0);
    capture(0, 1'b1, 1, bits, lr);
    chk_cnt++;
    if (bits !== 32'h12341234 || underflow !== 1'b0)
      $display("FAIL udf_first: got %h uf %b required 12341234 0", bits, underflow);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h12341234) $display("FAIL udf_repeat: got %h required 12341234", bits);
    else pass_cnt++;
    chk_cnt++;
    if (underflow !== 1'b1) $display("FAIL udf_flag: got %b required 1", underflow);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits, lr;
    int n;
    wait_mid();
    pulse_clr();
    push(18'h02AA8);
    push(18'h02EEC);
    chk_cnt++;
    if (fifo_level !== 2'd2) $display("FAIL b2b_full: got %0d required 2", fifo_level);
    else pass_cnt++;
    n = 0;
    while (i2s_lrclk !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    while (i2s_bclk !== 1'b1 && n < 420) begin @(negedge clk); n++; end
    chk_cnt++;
    if (n >= 400) $display("FAIL b2b_sync: got %0d cycles required under 400", n);
    else pass_cnt++;
    // bclk rose for bit 31; the wrap pop happens 4 clocks after that rise
    repeat (3) @(negedge clk);
    sound_valid = 1'b1;
    sound = 18'h03330;
    @(negedge clk);
    sound_valid = 1'b0;
    chk_cnt++;
    if (fifo_level !== 2'd2 || overflow !== 1'b0)
      $display("FAIL b2b_push_pop: got level %0d ovf %b required 2 0", fifo_level, overflow);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h0AAA0AAA) $display("FAIL b2b_a: got %h required 0aaa0aaa", bits);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h0BBB0BBB) $display("FAIL b2b_b: got %h required 0bbb0bbb", bits);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h0CCC0CCC) $display("FAIL b2b_c: got %h required 0ccc0ccc", bits);
    else pass_cnt++;
    chk_cnt++;
    if ({overflow, underflow} !== 2'b00)
      $display("FAIL b2b_flags: got %b required 00", {overflow, underflow});
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    logic [31:0] bits, lr;
    logic pb;
    int n, falls;
    wait_mid();
    push(18'h00444);
    push(18'h00888);
    push(18'h00CCC);
    chk_cnt++;
    if (fifo_level !== 2'd2 || overflow !== 1'b1)
      $display("FAIL rst_pre: got level %0d ovf %b required 2 1", fifo_level, overflow);
    else pass_cnt++;
    // move to bit 15 of the next frame, then five falls to bit 20
    wait_mid();
    falls = 0;
    n = 0;
    pb = i2s_bclk;
    while (falls < 5 && n < 100) begin
      @(negedge clk);
      n++;
      if (pb && !i2s_bclk) falls++;
      pb = i2s_bclk;
    end
    rst = 1'b1;
    sound_valid = 1'b1;
    sound = 18'h00444;
    @(negedge clk);
    chk_cnt++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underflow} !== 7'b0)
      $display("FAIL rst_mid_values: got %b required 0000000",
               {i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underflow});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    sound_valid = 1'b0;
    n = 0;
    while (i2s_bclk !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk_cnt++;
    if (n !== 4 || fifo_level !== 2'd0)
      $display("FAIL rst_mid_rise: got %0d cycles level %0d required 4 0", n, fifo_level);
    else pass_cnt++;
    capture(0, 1'b0, 0, bits, lr);
    chk_cnt++;
    if (bits !== 32'h0) $display("FAIL rst_mid_frame: got %h required 00000000", bits);
    else pass_cnt++;
    chk_cnt++;
    if ({overflow, underflow} !== 2'b01)
      $display("FAIL rst_mid_flags: got %b required 01", {overflow, underflow});
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    sound = '0;
    sound_valid = 1'b0;
    clr_status = 1'b0;
    sound_g2 = '0;
    valid_g2 = 1'b0;
    pass_cnt = 0;
    chk_cnt = 0;
    test_reset();
    test_conv();
    test_serial();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
